bc_display_scan: RTL and testbench
==================================

# bc_display_scan

Time-multiplexed driver for the 8-digit seven-segment display of the Bulls & Cows game. It sits between the game FSM's eight 6-bit digit codes and the board's shared segment/anode pins. A free-running prescaler steps through the eight digit slots with an anti-ghosting blank interval. All eight codes are captured into shadow registers once per frame, so a single frame never mixes old and new codes.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- d1..d8  in  6 each  digit codes {en_n, val[3:0], dp}.
  - en_n=1 means the digit is blank.
  - dp=1 means the decimal point is lit.
  - d1 drives an[0] (rightmost); d8 drives an[7] (leftmost).
- an  out  8  anode selects, active-low; at most one bit is 0 at any time.
- dec_ddp  out  8  segment pins, active-low: [7:1] = a,b,c,d,e,f,g; [0] = dp.
- frame_start  out  1  one-cycle pulse marking the start of each frame.

## Operation
- **Reset values:**
  - cnt=0, idx=0.
  - Shadow registers s1..s8 = 6'b111111.
  - an=8'hFF, dec_ddp=8'hFF, frame_start=0.
- **Prescaler cnt** (width $clog2(REFRESH_DIV)):
  - Counts 0 to REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx (3 bits) increments; 7 wraps to 0.
- **Frame latch:**
  - In any cycle with cnt==0 and idx==0, s1..s8 load d1..d8.
  - This includes the first cycle after reset deasserts.
  - Inputs are ignored at all other times.
- **Output register, evaluated each cycle from the current cnt, idx and shadow:**
  - If cnt < BLANK_CYCLES, or the selected shadow has en_n=1: next an=8'hFF and next dec_ddp=8'hFF.
  - Otherwise: next an has only bit idx at 0, next dec_ddp[7:1] = ~glyph(val), next dec_ddp[0] = ~dp.
- **Glyph map** (val: abcdefg, 1 = lit):
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111 (also used as G), 7:1110000
  - 8:1111111, 9:1111011
  - A→P:1100111, B→b:0011111, C→c:0001101, D→S:1011011, E→E:1001111, F→U:0111110
- **frame_start:** registered to 1 in the cycle after a frame-latch cycle; 0 otherwise.
- No handshake: inputs are level-sampled. The block never stalls.

## Timing
- **Slot length:** exactly REFRESH_DIV cycles. Frame length is 8·REFRESH_DIV cycles.
- **Output latency:** outputs lag (cnt, idx) by 1 cycle.
  - A slot entered at cycle t (cnt=0) shows an=8'hFF for cycles t+1 … t+BLANK_CYCLES.
  - The digit is driven from t+BLANK_CYCLES+1 through t+REFRESH_DIV, inclusive.
- **Input-to-display latency:**
  - A change on dk that is sampled at a latch cycle first appears when slot k-1 becomes active.
  - A change made after the latch cycle waits for the next frame, up to 8·REFRESH_DIV cycles later.
- **Reset mid-scan:**
  - Outputs go to their reset values immediately (asynchronous).
  - After release, the scan restarts at idx=0 with a fresh latch; no partial frame is resumed.
- **Simultaneous events:** when the idx 7→0 wrap and cnt=0 coincide, that cycle is the latch cycle.
- **Blank digits:** en_n=1 in the shadow keeps its anode off for the whole slot; the other slots are unaffected.

## Test plan
- **Reset:** hold reset for 3 cycles mid-slot (REFRESH_DIV=4, BLANK_CYCLES=1) -> an=8'hFF, dec_ddp=8'hFF, frame_start=0 asynchronously. After release, frame_start=1 exactly 1 cycle later.
- **Scan order:** REFRESH_DIV=4, BLANK_CYCLES=1, all inputs {0,val=k-1,0} -> an sequence per slot is FF, FE, FE, FE, then FF, FD, FD, FD, … through 7F. This repeats with a 32-cycle period, and frame_start pulses every 32 cycles.
- **Glyph decode:** sweep val 0..F on d1 with dp=1 -> on slot 0, dec_ddp matches ~{glyph,1}; e.g. val=A (P) gives 8'h30, val=0 gives 8'h02.
- **Tear-free latch:** change d3 from 5 to 2 while idx=4 -> slot 2 still shows 5 for the rest of this frame and shows 2 in the following frame.
- **Blank digit:** d5=6'b111111 -> an[4] never goes to 0; the other seven digits are driven normally.
- **Parameter bound:** REFRESH_DIV=2, BLANK_CYCLES=1 -> each digit is driven for exactly 1 cycle per slot; the idx 7→0 wrap latches new inputs.

Source files
------------

// File: rtl/bc_display_scan.sv
// -----------------------------------------------------------------------------
// bc_display_scan
// Time-multiplexed driver for an 8-digit seven-segment display.
// A prescaler steps through eight digit slots. Each slot starts with a blank
// interval to suppress ghosting. The eight digit codes are copied into shadow
// registers once per frame, so a single frame never mixes old and new codes.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : cycles at the start of each slot with all anodes off
//                  (1 <= BLANK_CYCLES < REFRESH_DIV)
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high reset
//   d1..d8       : digit codes {en_n, val[3:0], dp}; d1 -> an[0], d8 -> an[7]
//   an           : anode selects, active-low, at most one bit low
//   dec_ddp      : segments, active-low, [7:1] = a..g, [0] = dp
//   frame_start  : one-cycle pulse in the cycle after each frame latch
// -----------------------------------------------------------------------------
module bc_display_scan #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   output logic [7:0] an,
   output logic [7:0] dec_ddp,
   output logic       frame_start
);

   localparam int            CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt_reg;
   logic [2:0]    idx_reg;
   logic [5:0]    digit_in   [8];
   logic [5:0]    shadow_reg [8];
   logic [7:0]    an_reg;
   logic [7:0]    dec_ddp_reg;
   logic          frame_start_reg;

   logic          latch;
   logic [5:0]    sel;
   logic [6:0]    seg;
   logic          blank;
   logic [7:0]    an_next;
   logic [7:0]    dec_ddp_next;

   // Glyph table, abcdefg with 1 = lit. Hex letters are reused for the
   // game's status letters: A->P, B->b, C->c, D->S, E->E, F->U.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      g = 7'b0000000;
      case (v)
         4'h0: g = 7'b1111110;
         4'h1: g = 7'b0110000;
         4'h2: g = 7'b1101101;
         4'h3: g = 7'b1111001;
         4'h4: g = 7'b0110011;
         4'h5: g = 7'b1011011;
         4'h6: g = 7'b1011111;
         4'h7: g = 7'b1110000;
         4'h8: g = 7'b1111111;
         4'h9: g = 7'b1111011;
         4'hA: g = 7'b1100111;
         4'hB: g = 7'b0011111;
         4'hC: g = 7'b0001101;
         4'hD: g = 7'b1011011;
         4'hE: g = 7'b1001111;
         4'hF: g = 7'b0111110;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

   assign digit_in[0] = d1;
   assign digit_in[1] = d2;
   assign digit_in[2] = d3;
   assign digit_in[3] = d4;
   assign digit_in[4] = d5;
   assign digit_in[5] = d6;
   assign digit_in[6] = d7;
   assign digit_in[7] = d8;

   // The first cycle of slot 0 is the only time inputs are sampled. That
   // includes the first cycle after reset releases.
   assign latch = (cnt_reg == '0) && (idx_reg == 3'd0);

   // Prescaler and slot index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
         idx_reg <= 3'd0;
      end else if (cnt_reg == CNT_MAX) begin
         cnt_reg <= '0;
         idx_reg <= idx_reg + 3'd1;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   // Shadow copy of all eight codes, refreshed once per frame
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) shadow_reg[i] <= 6'h3F;
      end else if (latch) begin
         for (int i = 0; i < 8; i++) shadow_reg[i] <= digit_in[i];
      end
   end

   // Next outputs from the current slot position and shadow contents
   always_comb begin
      sel          = shadow_reg[idx_reg];
      seg          = glyph(sel[4:1]);
      blank        = (cnt_reg < BLANK_END) || sel[5];
      an_next      = 8'hFF;
      dec_ddp_next = 8'hFF;
      if (!blank) begin
         an_next      = ~(8'h01 << idx_reg);
         dec_ddp_next = {~seg, ~sel[0]};
      end
   end

   // Registered outputs, so the pins are glitch-free
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         an_reg          <= 8'hFF;
         dec_ddp_reg     <= 8'hFF;
         frame_start_reg <= 1'b0;
      end else begin
         an_reg          <= an_next;
         dec_ddp_reg     <= dec_ddp_next;
         frame_start_reg <= latch;
      end
   end

   assign an          = an_reg;
   assign dec_ddp     = dec_ddp_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_bc_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bc_display_scan
// Two instances run side by side from the same inputs: lane 0 with
// REFRESH_DIV=4 and lane 1 with REFRESH_DIV=2, both with BLANK_CYCLES=1.
// Each lane has a reference model. At every rising edge the model computes,
// from the elapsed cycle count, the slot, the phase and the frame-latched
// codes that the display must show. It pushes that expected value into a
// queue. A separate monitor pops the queue on each falling edge and compares.
// -----------------------------------------------------------------------------
module tb_bc_display_scan;

   localparam int BL = 1;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] dec;
      logic       fs;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] d_tb   [8];
   logic [7:0] an_w   [2];
   logic [7:0] dec_w  [2];
   logic       fs_w   [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   // Reference glyph table, abcdefg with 1 = lit
   function automatic logic [6:0] ref_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
         4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
         4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
         4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
         4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
         4'hA: g = 7'b1100111;  4'hB: g = 7'b0011111;
         4'hC: g = 7'b0001101;  4'hD: g = 7'b1011011;
         4'hE: g = 7'b1001111;  default: g = 7'b0111110;
      endcase
      return g;
   endfunction

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam int RD = (gi == 0) ? 4 : 2;

      exp_t       exp_q [$];
      logic [5:0] shadow [8];
      int         k = 0;

      bc_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
         .clock       (clock),
         .reset       (reset),
         .d1          (d_tb[0]),
         .d2          (d_tb[1]),
         .d3          (d_tb[2]),
         .d4          (d_tb[3]),
         .d5          (d_tb[4]),
         .d6          (d_tb[5]),
         .d7          (d_tb[6]),
         .d8          (d_tb[7]),
         .an          (an_w[gi]),
         .dec_ddp     (dec_w[gi]),
         .frame_start (fs_w[gi])
      );

      // k counts rising edges since reset release. Slot = (k/RD) mod 8 and
      // phase = k mod RD. A frame latch happens whenever k is a multiple
      // of 8*RD.
      always @(posedge clock) begin : model
         exp_t e;
         int   ph;
         int   sl;
         e.an  = 8'hFF;
         e.dec = 8'hFF;
         e.fs  = 1'b0;
         if (reset) begin
            k = 0;
         end else begin
            ph = k % RD;
            sl = (k / RD) % 8;
            if (k % (8 * RD) == 0) begin
               for (int i = 0; i < 8; i++) shadow[i] = d_tb[i];
               e.fs = 1'b1;
            end
            if (ph >= BL && !shadow[sl][5]) begin
               e.an     = 8'hFF;
               e.an[sl] = 1'b0;
               e.dec    = {~ref_glyph(shadow[sl][4:1]), ~shadow[sl][0]};
            end
            k++;
         end
         exp_q.push_back(e);
      end

      always @(negedge clock) begin : monitor
         exp_t e;
         exp_t a;
         a.an  = an_w[gi];
         a.dec = dec_w[gi];
         a.fs  = fs_w[gi];
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL lane%0d queue_empty: got an=%h dec=%h fs=%b, nothing expected",
                     gi, a.an, a.dec, a.fs);
         end else begin
            e = exp_q.pop_front();
            // Reset acts asynchronously, so it overrides the clocked prediction
            if (reset) begin
               e.an  = 8'hFF;
               e.dec = 8'hFF;
               e.fs  = 1'b0;
            end
            if (a !== e) begin
               n_fail++;
               $display("FAIL lane%0d scan t=%0t: got an=%h dec=%h fs=%b, expected an=%h dec=%h fs=%b",
                        gi, $time, a.an, a.dec, a.fs, e.an, e.dec, e.fs);
            end
         end
      end
   end

   task automatic set_digit(input int i, input logic [5:0] v);
      d_tb[i] = v;
      $display("[TB] t=%0t set d%0d = {en_n=%b val=%h dp=%b}", $time, i + 1, v[5], v[4:1], v[0]);
   endtask

   // Wait (bounded) until lane 0 shows frame_start. Stimulus steps are then
   // aligned to the frame.
   task automatic wait_frame();
      int n;
      n = 0;
      while (fs_w[0] !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (fs_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_sync: got frame_start=%b, expected 1 within 40 cycles", fs_w[0]);
      end
   endtask

   task automatic check_reset_outputs(input int lane);
      n_tests++;
      if (an_w[lane] !== 8'hFF || dec_w[lane] !== 8'hFF || fs_w[lane] !== 1'b0) begin
         n_fail++;
         $display("FAIL lane%0d async_reset: got an=%h dec=%h fs=%b, expected an=ff dec=ff fs=0",
                  lane, an_w[lane], dec_w[lane], fs_w[lane]);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) d_tb[i] = 6'h3F;
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // Scan order: digit k shows value k-1
      for (int i = 0; i < 8; i++) set_digit(i, {1'b0, 4'(i), 1'b0});
      reset = 1'b0;
      repeat (70) @(negedge clock);

      // Glyph sweep on d1 with the decimal point lit
      for (int v = 0; v < 16; v++) begin
         set_digit(0, {1'b0, 4'(v), 1'b1});
         repeat (32) @(negedge clock);
      end

      // Blank digit 5; the other digits keep scanning
      set_digit(4, 6'h3F);
      repeat (70) @(negedge clock);
      set_digit(4, {1'b0, 4'h4, 1'b0});

      // Tear-free latch: d3 changes while lane 0 is in slot 4
      set_digit(2, {1'b0, 4'h5, 1'b0});
      repeat (2) @(negedge clock);
      wait_frame();
      repeat (16) @(negedge clock);
      set_digit(2, {1'b0, 4'h2, 1'b0});
      repeat (70) @(negedge clock);

      // Random code changes at random moments
      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         if ($urandom_range(5) == 0)
            set_digit(int'($urandom_range(7)),
                      {($urandom_range(3) == 0), 4'($urandom_range(15)), 1'($urandom_range(1))});
      end

      // Reset mid-slot, while lane 0 drives digit 2
      for (int i = 0; i < 8; i++) set_digit(i, {1'b0, 4'($urandom_range(15)), 1'($urandom_range(1))});
      repeat (2) @(negedge clock);
      wait_frame();
      repeat (6) @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs(0);
      check_reset_outputs(1);
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // More random traffic after the restart
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if ($urandom_range(5) == 0)
            set_digit(int'($urandom_range(7)),
                      {($urandom_range(3) == 0), 4'($urandom_range(15)), 1'($urandom_range(1))});
      end

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
